// File: rtl/drag_object_ctl_pkg.sv
// drag_object_ctl_pkg: shared state encoding, widths and screen constants for the drag controller.
package drag_object_ctl_pkg;
  localparam int POS_W = 12;
  localparam int CNT_W = 11;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SCAN = 3'd1;
  localparam logic [2:0] SELECT = 3'd2;
  localparam logic [2:0] DRAG = 3'd3;
  localparam logic [2:0] WAIT_REL = 3'd4;
endpackage

// File: rtl/drag_object_ctl_prio_enc_msb.sv
// prio_enc_msb: index of the highest set bit of a multi-hot vector, plus any-set flag.
module prio_enc_msb #(
  parameter int N = 4
) (
  input  logic [N-1:0] in_i,
  output logic [2:0]   idx_o,
  output logic         valid_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) idx_o = in_i[i] ? 3'(i) : idx_o;
  end
  assign valid_o = |in_i;
endmodule

// File: rtl/drag_object_ctl.sv
// drag_object_ctl: grants the mouse to the topmost object under a left-click and drags it once per frame.
module drag_object_ctl
  import drag_object_ctl_pkg::*;
#(
  parameter int         N_OBJ = 4,
  parameter logic [11:0] X_MAX = 12'd736,
  parameter logic [11:0] Y_MAX = 12'd536,
  parameter logic [11:0] X0    = 12'd100,
  parameter logic [11:0] Y0    = 12'd100
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       hcount_in,
  input  logic [CNT_W-1:0]       vcount_in,
  input  logic [POS_W-1:0]       xpos_mouse,
  input  logic [POS_W-1:0]       ypos_mouse,
  input  logic                   mouse_left,
  input  logic [N_OBJ-1:0]       obj_hit,
  output logic [POS_W*N_OBJ-1:0] obj_xpos,
  output logic [POS_W*N_OBJ-1:0] obj_ypos,
  output logic [2:0]             sel_id,
  output logic                   sel_valid,
  output logic                   busy
);
  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  logic [2:0] state_q, state_d;
  logic ml_q, seen_tick_q;
  logic [POS_W-1:0] x_lat_q, y_lat_q, off_x_q, off_y_q;
  logic [N_OBJ-1:0] hit_q;
  logic [2:0] sel_q, enc_idx;
  logic enc_valid;
  logic [POS_W-1:0] pos_x_q [N_OBJ];
  logic [POS_W-1:0] pos_y_q [N_OBJ];
  logic press, frame_tick, match;
  logic [POS_W:0] new_x, new_y;
  logic [POS_W-1:0] clamp_x, clamp_y;
  assign press = mouse_left & ~ml_q;
  assign frame_tick = (hcount_in == '0) && (vcount_in == '0);
  assign match = (hcount_in == x_lat_q[CNT_W-1:0]) && (vcount_in == y_lat_q[CNT_W-1:0]);
  prio_enc_msb #(.N(N_OBJ)) u_prio (
    .in_i   (hit_q),
    .idx_o  (enc_idx),
    .valid_o(enc_valid)
  );
  // bit POS_W of the difference is the sign: mouse left of / above the grab offset
  assign new_x = {1'b0, xpos_mouse} - {1'b0, off_x_q};
  assign new_y = {1'b0, ypos_mouse} - {1'b0, off_y_q};
  assign clamp_x = new_x[POS_W] ? '0 : (new_x[POS_W-1:0] > X_MAX ? X_MAX : new_x[POS_W-1:0]);
  assign clamp_y = new_y[POS_W] ? '0 : (new_y[POS_W-1:0] > Y_MAX ? Y_MAX : new_y[POS_W-1:0]);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = press ? SCAN : IDLE;
      SCAN:    state_d = match ? SELECT : ((frame_tick && seen_tick_q) ? WAIT_REL : SCAN);
      SELECT:  state_d = enc_valid ? DRAG : WAIT_REL;
      default: state_d = state_q;
    endcase
    if (state_q != IDLE && !mouse_left) state_d = IDLE;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= IDLE;
      ml_q        <= 1'b0;
      seen_tick_q <= 1'b0;
      x_lat_q     <= '0;
      y_lat_q     <= '0;
      off_x_q     <= '0;
      off_y_q     <= '0;
      hit_q       <= '0;
      sel_q       <= '0;
      for (int k = 0; k < N_OBJ; k++) begin
        pos_x_q[k] <= X0 + POS_W'(150 * k);
        pos_y_q[k] <= Y0;
      end
    end else begin
      state_q <= state_d;
      ml_q    <= mouse_left;
      if (state_q == IDLE && press) begin
        x_lat_q     <= xpos_mouse;
        y_lat_q     <= ypos_mouse;
        seen_tick_q <= 1'b0;
        hit_q       <= '0;
      end
      if (state_q == SCAN && match) hit_q <= obj_hit;
      if (state_q == SCAN && !match && frame_tick) seen_tick_q <= 1'b1;
      if (state_q == SELECT && enc_valid) begin
        sel_q   <= enc_idx;
        off_x_q <= x_lat_q - pos_x_q[enc_idx[IW-1:0]];
        off_y_q <= y_lat_q - pos_y_q[enc_idx[IW-1:0]];
      end
      // applied even when the button is released on this very tick
      if (state_q == DRAG && frame_tick) begin
        pos_x_q[sel_q[IW-1:0]] <= clamp_x;
        pos_y_q[sel_q[IW-1:0]] <= clamp_y;
      end
    end
  end
  for (genvar k = 0; k < N_OBJ; k++) begin : g_pack
    assign obj_xpos[POS_W*k +: POS_W] = pos_x_q[k];
    assign obj_ypos[POS_W*k +: POS_W] = pos_y_q[k];
  end
  assign sel_id    = sel_q;
  assign sel_valid = (state_q == DRAG);
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_drag_object_ctl.sv
// tb_drag_object_ctl: directed checks of grab, drag, overlap priority, clamping, timeout and reset.
module tb_drag_object_ctl;
  logic pclk = 1'b0;
  logic rst = 1'b1;
  logic [10:0] hcount_in = 11'd5, vcount_in = 11'd5;
  logic [11:0] xpos_mouse = '0, ypos_mouse = '0;
  logic mouse_left = 1'b0;
  logic [3:0] obj_hit = '0;
  logic [47:0] obj_xpos, obj_ypos;
  logic [2:0] sel_id;
  logic sel_valid, busy;
  int tests = 0, fails = 0;
  localparam logic [47:0] X_INIT = {12'd550, 12'd400, 12'd250, 12'd100};
  localparam logic [47:0] Y_INIT = {4{12'd100}};
  drag_object_ctl dut (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .xpos_mouse(xpos_mouse), .ypos_mouse(ypos_mouse), .mouse_left(mouse_left),
    .obj_hit(obj_hit), .obj_xpos(obj_xpos), .obj_ypos(obj_ypos),
    .sel_id(sel_id), .sel_valid(sel_valid), .busy(busy)
  );
  always #5 pclk = ~pclk;
  task automatic step();
    @(posedge pclk);
    #1;
  endtask
  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic press_at(input logic [11:0] x, input logic [11:0] y, input logic [3:0] hit);
    xpos_mouse = x; ypos_mouse = y; mouse_left = 1'b1;
    hcount_in = 11'd5; vcount_in = 11'd5;
    step();
    hcount_in = x[10:0]; vcount_in = y[10:0]; obj_hit = hit;
    step();
    hcount_in = x[10:0] + 11'd1; obj_hit = '0;
    step();
  endtask
  task automatic frame();
    hcount_in = 11'd0; vcount_in = 11'd0;
    step();
    hcount_in = 11'd1;
  endtask
  task automatic release_btn();
    mouse_left = 1'b0;
    step();
  endtask
  initial begin
    step(); step();
    rst = 1'b0;
    step();
    check("rst_x", obj_xpos, X_INIT);
    check("rst_y", obj_ypos, Y_INIT);
    check("rst_valid", 48'(sel_valid), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_sel", 48'(sel_id), 48'd0);
    press_at(12'd120, 12'd110, 4'b0001);
    check("grab0_sel", 48'(sel_id), 48'd0);
    check("grab0_valid", 48'(sel_valid), 48'd1);
    check("grab0_busy", 48'(busy), 48'd1);
    xpos_mouse = 12'd320; ypos_mouse = 12'd210;
    step();
    check("no_move_before_tick", obj_xpos, X_INIT);
    frame();
    check("drag0_x", obj_xpos, {12'd550, 12'd400, 12'd250, 12'd300});
    check("drag0_y", obj_ypos, {12'd100, 12'd100, 12'd100, 12'd200});
    release_btn();
    check("rel0_busy", 48'(busy), 48'd0);
    check("rel0_valid", 48'(sel_valid), 48'd0);
    press_at(12'd420, 12'd120, 4'b0110);
    check("ovl_sel", 48'(sel_id), 48'd2);
    check("ovl_valid", 48'(sel_valid), 48'd1);
    xpos_mouse = 12'd500; ypos_mouse = 12'd300;
    frame();
    check("ovl_x", obj_xpos, {12'd550, 12'd480, 12'd250, 12'd300});
    check("ovl_y", obj_ypos, {12'd100, 12'd280, 12'd100, 12'd200});
    release_btn();
    press_at(12'd700, 12'd500, 4'b0000);
    check("bg_busy", 48'(busy), 48'd1);
    check("bg_valid", 48'(sel_valid), 48'd0);
    xpos_mouse = 12'd10; ypos_mouse = 12'd10;
    frame();
    check("bg_x", obj_xpos, {12'd550, 12'd480, 12'd250, 12'd300});
    check("bg_y", obj_ypos, {12'd100, 12'd280, 12'd100, 12'd200});
    release_btn();
    check("bg_rel_busy", 48'(busy), 48'd0);
    xpos_mouse = 12'd2000; ypos_mouse = 12'd700; mouse_left = 1'b1;
    step();
    frame();
    frame();
    check("tmo_busy", 48'(busy), 48'd1);
    hcount_in = 11'd2000; vcount_in = 11'd700; obj_hit = 4'b0001;
    step(); step();
    check("tmo_no_grab", 48'(sel_valid), 48'd0);
    obj_hit = '0; hcount_in = 11'd5; vcount_in = 11'd5;
    release_btn();
    check("tmo_rel_busy", 48'(busy), 48'd0);
    press_at(12'd320, 12'd210, 4'b0001);
    check("clamp_sel", 48'(sel_id), 48'd0);
    xpos_mouse = 12'd5; ypos_mouse = 12'd700;
    frame();
    check("clamp_lo_x_hi_y", {obj_xpos[11:0], obj_ypos[11:0]}, {24'd0, 12'd0, 12'd536});
    xpos_mouse = 12'd900; ypos_mouse = 12'd3;
    frame();
    check("clamp_hi_x_lo_y", {obj_xpos[11:0], obj_ypos[11:0]}, {24'd0, 12'd736, 12'd0});
    check("clamp_others_x", {12'd0, obj_xpos[47:12]}, {12'd0, 12'd550, 12'd480, 12'd250});
    xpos_mouse = 12'd320; ypos_mouse = 12'd210;
    mouse_left = 1'b0;
    frame();
    check("rel_tick_pos", {obj_xpos[11:0], obj_ypos[11:0]}, {24'd0, 12'd300, 12'd200});
    check("rel_tick_busy", 48'(busy), 48'd0);
    check("rel_tick_valid", 48'(sel_valid), 48'd0);
    press_at(12'd560, 12'd110, 4'b1000);
    check("obj3_sel", 48'(sel_id), 48'd3);
    xpos_mouse = 12'd600; ypos_mouse = 12'd400;
    frame();
    check("obj3_x", obj_xpos, {12'd590, 12'd480, 12'd250, 12'd300});
    check("obj3_y", obj_ypos, {12'd390, 12'd280, 12'd100, 12'd200});
    rst = 1'b1;
    step();
    check("midrst_x", obj_xpos, X_INIT);
    check("midrst_y", obj_ypos, Y_INIT);
    check("midrst_busy", 48'(busy), 48'd0);
    check("midrst_valid", 48'(sel_valid), 48'd0);
    check("midrst_sel", 48'(sel_id), 48'd0);
    rst = 1'b0;
    mouse_left = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
